ibuf_issue_queue: RTL and testbench

- Parametrised instruction buffer between IF and ID.
- Generalises the single-entry ID pipeline register (valid/allowin) into a DEPTH-entry circular queue.
- Accepts up to FETCH_W instructions per cycle and presents up to ISSUE_W instructions per cycle to decode.
- Enforces the MIPS delay-slot rule: a branch is never visible to ID unless its delay slot is already buffered.
- Flushes on exception, eret, refetch and wait.

---
 rtl/ibuf_pkg.sv | 34 +++
 rtl/ibuf_ram.sv | 36 +++
 rtl/ibuf_issue_queue.sv | 127 ++++++++++++
 tb/tb_ibuf_issue_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared constants for the IF->ID instruction buffer: default geometry,
// derived pointer/count widths and the payload field layout used by IF and ID.
package ibuf_pkg;

  localparam int IBUF_DEPTH    = 8;
  localparam int IBUF_FETCH_W  = 2;
  localparam int IBUF_ISSUE_W  = 2;
  localparam int IBUF_ENTRY_WD = 136;

  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);
  localparam int IBUF_CNT_W = $clog2(IBUF_DEPTH + 1);

  // Payload layout: pc | inst | exception info | bad vaddr | predicted target
  localparam int IBUF_PC_LSB    = 0;
  localparam int IBUF_PC_W      = 32;
  localparam int IBUF_INST_LSB  = 32;
  localparam int IBUF_INST_W    = 32;
  localparam int IBUF_EXC_LSB   = 64;
  localparam int IBUF_EXC_W     = 8;
  localparam int IBUF_BADVA_LSB = 72;
  localparam int IBUF_BADVA_W   = 32;
  localparam int IBUF_PRED_LSB  = 104;
  localparam int IBUF_PRED_W    = 32;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ibuf_ram.sv
// Instruction buffer storage: register array with several write ports and
// combinational read ports. Contents are intentionally not reset.
module ibuf_ram #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int WIDTH    = 137,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                clk,
  input  logic [WR_PORTS-1:0] wr_en,
  input  logic [ADDR_W-1:0]   wr_addr [WR_PORTS],
  input  logic [WIDTH-1:0]    wr_data [WR_PORTS],
  input  logic [ADDR_W-1:0]   rd_addr [RD_PORTS],
  output logic [WIDTH-1:0]    rd_data [RD_PORTS]
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write ports always target distinct entries, so port order does not matter.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WR_PORTS; k++) begin
      if (wr_en[k]) begin
        mem_r[wr_addr[k]] <= wr_data[k];
      end
    end
  end

  // Asynchronous read ports.
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i] = mem_r[rd_addr[i]];
    end
  end

endmodule

// File: rtl/ibuf_issue_queue.sv
// Multi-entry instruction buffer between IF and ID; a branch is only exposed to
// decode once its delay slot is also buffered.
module ibuf_issue_queue
  import ibuf_pkg::*;
#(
  parameter int DEPTH    = IBUF_DEPTH,
  parameter int FETCH_W  = IBUF_FETCH_W,
  parameter int ISSUE_W  = IBUF_ISSUE_W,
  parameter int ENTRY_WD = IBUF_ENTRY_WD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FETCH_W-1:0]            IF_valid,
  input  logic [FETCH_W-1:0]            IF_is_branch,
  input  logic [FETCH_W*ENTRY_WD-1:0]   IF_to_ibuf_bus,
  output logic                          ibuf_allowin,
  output logic [ISSUE_W-1:0]            ibuf_valid,
  output logic [ISSUE_W-1:0]            ibuf_is_branch,
  output logic [ISSUE_W*ENTRY_WD-1:0]   ibuf_to_ID_bus,
  input  logic [$clog2(ISSUE_W+1)-1:0]  ID_pop,
  output logic [$clog2(DEPTH+1)-1:0]    ibuf_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int POP_W  = $clog2(ISSUE_W + 1);
  localparam int PUSH_W = $clog2(FETCH_W + 1);
  localparam int RAM_W  = ENTRY_WD + 1;
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(DEPTH - FETCH_W);

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic              do_push_s;
  logic [PUSH_W-1:0] push_n_s;
  logic [PUSH_W-1:0] push_eff_s;
  logic [POP_W-1:0]  vis_n_s;
  logic [POP_W-1:0]  pop_s;
  logic [ISSUE_W-1:0] vis_s;
  logic              chain_s;

  logic [FETCH_W-1:0] wr_en_s;
  logic [PTR_W-1:0]   wr_addr_s [FETCH_W];
  logic [RAM_W-1:0]   wr_data_s [FETCH_W];
  logic [PTR_W-1:0]   rd_addr_s [ISSUE_W];
  logic [RAM_W-1:0]   rd_data_s [ISSUE_W];

  // Space check uses only registered occupancy, so a same-cycle pop never
  // lengthens the combinational path back to IF.
  assign ibuf_allowin = (count_r <= FULL_LIM);
  assign ibuf_count   = count_r;

  // Push lane mapping and read-window addressing.
  always_comb begin
    push_n_s   = PUSH_W'(popcount4(4'(IF_valid)));
    do_push_s  = ibuf_allowin && !flush;
    if (do_push_s) begin
      push_eff_s = push_n_s;
    end else begin
      push_eff_s = '0;
    end
    for (int k = 0; k < FETCH_W; k++) begin
      wr_en_s[k]   = do_push_s && IF_valid[k];
      wr_addr_s[k] = tail_r + PTR_W'(k);
      wr_data_s[k] = {IF_is_branch[k], IF_to_ibuf_bus[k*ENTRY_WD +: ENTRY_WD]};
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      rd_addr_s[i] = head_r + PTR_W'(i);
    end
  end

  ibuf_ram #(
    .DEPTH    (DEPTH),
    .ADDR_W   (PTR_W),
    .WIDTH    (RAM_W),
    .WR_PORTS (FETCH_W),
    .RD_PORTS (ISSUE_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Visibility scan: a branch without its delay slot stops the window.
  always_comb begin
    vis_s   = '0;
    vis_n_s = '0;
    chain_s = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      ibuf_is_branch[i]                     = rd_data_s[i][ENTRY_WD];
      ibuf_to_ID_bus[i*ENTRY_WD +: ENTRY_WD] = rd_data_s[i][ENTRY_WD-1:0];
      chain_s = chain_s && (CNT_W'(i) < count_r) &&
                (!rd_data_s[i][ENTRY_WD] || (CNT_W'(i + 1) < count_r));
      vis_s[i] = chain_s;
      vis_n_s  = vis_n_s + POP_W'(chain_s);
    end
    if (flush) begin
      ibuf_valid = '0;
    end else begin
      ibuf_valid = vis_s;
    end
    if (ID_pop > vis_n_s) begin
      pop_s = vis_n_s;
    end else begin
      pop_s = ID_pop;
    end
  end

  // Pointer and occupancy update; flush discards the same-cycle push and pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(pop_s);
      tail_r  <= tail_r + PTR_W'(push_eff_s);
      count_r <= count_r + CNT_W'(push_eff_s) - CNT_W'(pop_s);
    end
  end

endmodule

// File: tb/tb_ibuf_issue_queue.sv
// Bench for ibuf_issue_queue: directed vector table plus randomized traffic
// compared against a queue-based reference model.
module tb_ibuf_issue_queue;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int EW    = 136;

  logic           clk = 1'b0;
  logic           reset, flush;
  logic [FW-1:0]  IF_valid, IF_is_branch;
  logic [FW*EW-1:0] IF_to_ibuf_bus;
  logic           ibuf_allowin;
  logic [IW-1:0]  ibuf_valid, ibuf_is_branch;
  logic [IW*EW-1:0] ibuf_to_ID_bus;
  logic [1:0]     ID_pop;
  logic [3:0]     ibuf_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          br;
    logic [EW-1:0] pay;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  br;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  pop;
    logic        fl;
    logic [1:0]  ev;
    logic [3:0]  ec;
    logic        ea;
    logic [31:0] epc0;
    logic [31:0] epc1;
  } vec_t;
  vec_t tbl[22];

  ibuf_issue_queue dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .IF_valid       (IF_valid),
    .IF_is_branch   (IF_is_branch),
    .IF_to_ibuf_bus (IF_to_ibuf_bus),
    .ibuf_allowin   (ibuf_allowin),
    .ibuf_valid     (ibuf_valid),
    .ibuf_is_branch (ibuf_is_branch),
    .ibuf_to_ID_bus (ibuf_to_ID_bus),
    .ID_pop         (ID_pop),
    .ibuf_count     (ibuf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] pc);
    return {72'd0, ~pc, pc};
  endfunction

  function automatic vec_t mkv(input logic [1:0] iv, input logic [1:0] br,
                               input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic [1:0] pop, input logic fl,
                               input logic [1:0] ev, input logic [3:0] ec,
                               input logic ea, input logic [31:0] epc0,
                               input logic [31:0] epc1);
    vec_t v;
    v.iv = iv; v.br = br; v.pc0 = pc0; v.pc1 = pc1; v.pop = pop; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ea = ea; v.epc0 = epc0; v.epc1 = epc1;
    return v;
  endfunction

  // Decode-visible prefix length derived from the delay-slot rule.
  function automatic int model_vis();
    int v = 0;
    for (int i = 0; i < IW; i++) begin
      if (i >= mq.size()) break;
      if (mq[i].br && (i + 1 >= mq.size())) break;
      v++;
    end
    return v;
  endfunction

  task automatic step(input logic rst, input logic fl, input logic [1:0] iv,
                      input logic [1:0] br, input logic [EW-1:0] p0,
                      input logic [EW-1:0] p1, input logic [1:0] pop);
    int   vis;
    int   np;
    logic alw;
    logic [1:0] ev;
    ent_t e;
    @(negedge clk);
    reset = rst; flush = fl; IF_valid = iv; IF_is_branch = br;
    IF_to_ibuf_bus = {p1, p0}; ID_pop = pop;
    #1;
    vis = model_vis();
    alw = ((DEPTH - mq.size()) >= FW);
    if (!rst) begin
      for (int i = 0; i < IW; i++) ev[i] = (!fl) && (i < vis);
      chk("m_valid", EW'(ibuf_valid), EW'(ev));
      chk("m_count", EW'(ibuf_count), EW'(mq.size()));
      chk("m_allowin", EW'(ibuf_allowin), EW'(alw));
      for (int i = 0; i < IW; i++) begin
        if (!fl && i < vis) begin
          chk("m_branch", EW'(ibuf_is_branch[i]), EW'(mq[i].br));
          chk("m_payload", ibuf_to_ID_bus[i*EW +: EW], mq[i].pay);
        end
      end
    end
    if (rst || fl) begin
      mq.delete();
    end else begin
      np = (int'(pop) < vis) ? int'(pop) : vis;
      repeat (np) void'(mq.pop_front());
      if (alw) begin
        if (iv[0]) begin e.br = br[0]; e.pay = p0; mq.push_back(e); end
        if (iv[1]) begin e.br = br[1]; e.pay = p1; mq.push_back(e); end
      end
    end
  endtask

  initial begin
    vec_t v;
    int   vis;
    int   n;
    logic [1:0] iv;
    logic [1:0] pop;
    logic fl;
    logic rst;

    reset = 1'b1; flush = 1'b0; IF_valid = '0; IF_is_branch = '0;
    IF_to_ibuf_bus = '0; ID_pop = '0;

    tbl[0]  = mkv(2'b11, 2'b00, 32'h1000, 32'h1004, 2'd0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,    32'h0);
    tbl[1]  = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 2'b11, 4'd2, 1'b1, 32'h1000, 32'h1004);
    tbl[2]  = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,    32'h0);
    tbl[3]  = mkv(2'b01, 2'b01, 32'h2000, 32'h0,    2'd0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,    32'h0);
    tbl[4]  = mkv(2'b01, 2'b00, 32'h2004, 32'h0,    2'd0, 1'b0, 2'b00, 4'd1, 1'b1, 32'h0,    32'h0);
    tbl[5]  = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd0, 1'b0, 2'b11, 4'd2, 1'b1, 32'h2000, 32'h2004);
    tbl[6]  = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 2'b11, 4'd2, 1'b1, 32'h2000, 32'h2004);
    tbl[7]  = mkv(2'b11, 2'b00, 32'h3000, 32'h3004, 2'd0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,    32'h0);
    tbl[8]  = mkv(2'b11, 2'b00, 32'h3008, 32'h300c, 2'd0, 1'b0, 2'b11, 4'd2, 1'b1, 32'h3000, 32'h3004);
    tbl[9]  = mkv(2'b11, 2'b00, 32'h3010, 32'h3014, 2'd0, 1'b0, 2'b11, 4'd4, 1'b1, 32'h3000, 32'h3004);
    tbl[10] = mkv(2'b11, 2'b00, 32'h3018, 32'h301c, 2'd0, 1'b0, 2'b11, 4'd6, 1'b1, 32'h3000, 32'h3004);
    tbl[11] = mkv(2'b11, 2'b00, 32'h3020, 32'h3024, 2'd0, 1'b0, 2'b11, 4'd8, 1'b0, 32'h3000, 32'h3004);
    tbl[12] = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 2'b11, 4'd8, 1'b0, 32'h3000, 32'h3004);
    tbl[13] = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 2'b11, 4'd6, 1'b1, 32'h3008, 32'h300c);
    tbl[14] = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd2, 1'b0, 2'b11, 4'd4, 1'b1, 32'h3010, 32'h3014);
    tbl[15] = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd1, 1'b0, 2'b11, 4'd2, 1'b1, 32'h3018, 32'h301c);
    tbl[16] = mkv(2'b11, 2'b00, 32'h4000, 32'h4004, 2'd0, 1'b0, 2'b01, 4'd1, 1'b1, 32'h301c, 32'h0);
    tbl[17] = mkv(2'b11, 2'b00, 32'h4008, 32'h400c, 2'd1, 1'b0, 2'b11, 4'd3, 1'b1, 32'h301c, 32'h4000);
    tbl[18] = mkv(2'b01, 2'b00, 32'h4010, 32'h0,    2'd0, 1'b0, 2'b11, 4'd4, 1'b1, 32'h4000, 32'h4004);
    tbl[19] = mkv(2'b11, 2'b00, 32'h4014, 32'h4018, 2'd2, 1'b1, 2'b00, 4'd5, 1'b1, 32'h0,    32'h0);
    tbl[20] = mkv(2'b11, 2'b00, 32'h5000, 32'h5004, 2'd0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,    32'h0);
    tbl[21] = mkv(2'b00, 2'b00, 32'h0,    32'h0,    2'd0, 1'b0, 2'b11, 4'd2, 1'b1, 32'h5000, 32'h5004);

    step(1'b1, 1'b0, 2'b00, 2'b00, '0, '0, 2'd0);
    step(1'b1, 1'b0, 2'b00, 2'b00, '0, '0, 2'd0);

    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 2'b00, 2'b00, '0, '0, 2'd0);
      chk("idle_valid", EW'(ibuf_valid), EW'(2'b00));
      chk("idle_count", EW'(ibuf_count), EW'(4'd0));
      chk("idle_allowin", EW'(ibuf_allowin), EW'(1'b1));
    end

    for (int r = 0; r < 22; r++) begin
      v = tbl[r];
      step(1'b0, v.fl, v.iv, v.br, mk(v.pc0), mk(v.pc1), v.pop);
      chk($sformatf("vec%0d_valid", r), EW'(ibuf_valid), EW'(v.ev));
      chk($sformatf("vec%0d_count", r), EW'(ibuf_count), EW'(v.ec));
      chk($sformatf("vec%0d_allowin", r), EW'(ibuf_allowin), EW'(v.ea));
      if (v.ev[0]) chk($sformatf("vec%0d_pc0", r), EW'(ibuf_to_ID_bus[31:0]), EW'(v.epc0));
      if (v.ev[1]) chk($sformatf("vec%0d_pc1", r), EW'(ibuf_to_ID_bus[EW+31:EW]), EW'(v.epc1));
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      n   = $urandom_range(0, 2);
      iv  = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      vis = model_vis();
      pop = 2'($urandom_range(0, vis));
      fl  = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, fl, iv, 2'($urandom_range(0, 3)),
           EW'({$urandom, $urandom, $urandom, $urandom, $urandom}),
           EW'({$urandom, $urandom, $urandom, $urandom, $urandom}), pop);
    end

    // Reset together with flush behaves as reset.
    step(1'b1, 1'b1, 2'b11, 2'b00, mk(32'h6000), mk(32'h6004), 2'd0);
    step(1'b0, 1'b0, 2'b00, 2'b00, '0, '0, 2'd0);
    chk("rstfl_count", EW'(ibuf_count), EW'(4'd0));
    chk("rstfl_valid", EW'(ibuf_valid), EW'(2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
